// File: rtl/block_stream_emitter_pkg.sv
// Shared types and constants for the block stream emitter.
package block_stream_pkg;

  typedef enum logic [1:0] {
    OP_OPEN  = 2'b00,
    OP_CLOSE = 2'b01,
    OP_IDENT = 2'b10,
    OP_FLUSH = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_EMIT  = 2'b01,
    ST_FLUSH = 2'b10
  } state_e;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_B     = 8'h62;
  localparam logic [7:0] CH_E     = 8'h65;
  localparam logic [7:0] CH_G     = 8'h67;
  localparam logic [7:0] CH_I     = 8'h69;
  localparam logic [7:0] CH_N     = 8'h6E;
  localparam logic [7:0] CH_D     = 8'h64;

  localparam logic [2:0] LEN_OPEN  = 3'd6;
  localparam logic [2:0] LEN_CLOSE = 3'd4;
  localparam logic [2:0] LEN_IDENT = 3'd2;

  // Token length in characters, leading space included; FLUSH emits " end".
  function automatic logic [2:0] tok_len(input op_e op);
    case (op)
      OP_OPEN:  return LEN_OPEN;
      OP_IDENT: return LEN_IDENT;
      default:  return LEN_CLOSE;
    endcase
  endfunction

  function automatic logic is_lower(input logic [7:0] c);
    return (c >= 8'h61) && (c <= 8'h7A);
  endfunction

endpackage

// File: rtl/block_stream_emitter_if.sv
// Command and character-stream handshakes of the emitter.
// master: command source / character sink; slave: the emitter.
interface block_stream_emitter_if;
  import block_stream_pkg::*;

  logic       cmd_valid;
  logic       cmd_ready;
  op_e        cmd_op;
  logic [7:0] cmd_char;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_char;

  modport master (
    output cmd_valid, cmd_op, cmd_char, out_ready,
    input  cmd_ready, out_valid, out_char
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_char, out_ready,
    output cmd_ready, out_valid, out_char
  );
endinterface

// File: rtl/block_stream_emitter_token_rom.sv
// Character lookup for a token position; idx 0 is always the leading space.
module token_rom
  import block_stream_pkg::*;
#(
  parameter logic [7:0] IDENT_DEF = 8'h78
) (
  input  op_e        op_i,
  input  logic [2:0] idx_i,
  input  logic [7:0] ident_i,
  output logic [7:0] char_o
);

  // Per-op character table; non-lowercase identifiers are replaced.
  always_comb begin
    char_o = CH_SPACE;
    case (op_i)
      OP_OPEN: begin
        case (idx_i)
          3'd1:    char_o = CH_B;
          3'd2:    char_o = CH_E;
          3'd3:    char_o = CH_G;
          3'd4:    char_o = CH_I;
          3'd5:    char_o = CH_N;
          default: char_o = CH_SPACE;
        endcase
      end
      OP_IDENT: begin
        if (idx_i == 3'd1) char_o = is_lower(ident_i) ? ident_i : IDENT_DEF;
      end
      default: begin
        case (idx_i)
          3'd1:    char_o = CH_E;
          3'd2:    char_o = CH_N;
          3'd3:    char_o = CH_D;
          default: char_o = CH_SPACE;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/block_stream_emitter.sv
// Serialises OPEN/CLOSE/IDENT/FLUSH commands into a space-separated
// begin/end character stream while tracking nesting depth.
// Optional macro CASE_MIX_EN: alternate letters are emitted uppercase.
module block_stream_emitter
  import block_stream_pkg::*;
#(
  parameter int         DEPTH_W   = 8,
  parameter logic [7:0] IDENT_DEF = 8'h78
) (
  input  logic                   clk,
  input  logic                   reset,
  block_stream_emitter_if.slave  bus,
  output logic [DEPTH_W-1:0]     depth,
  output logic                   balanced,
  output logic                   err
);

  localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;
  localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);

  state_e             state_q;
  op_e                op_q;
  logic [7:0]         id_q;
  logic [2:0]         idx_q;
  logic               out_valid_q;
  logic [7:0]         out_char_q;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               err_q, err_d, balanced_q;

  logic       acc, reject, xfer, last;
  logic [2:0] idx_nxt;
  logic [7:0] rom_char, nxt_char;

  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_char  = out_char_q;
  assign depth         = depth_q;
  assign err           = err_q;
  assign balanced      = balanced_q;

  assign acc     = bus.cmd_valid && bus.cmd_ready;
  assign reject  = acc && (((bus.cmd_op == OP_CLOSE) && (depth_q == '0)) ||
                           ((bus.cmd_op == OP_OPEN)  && (depth_q == DEPTH_MAX)));
  assign xfer    = out_valid_q && bus.out_ready;
  assign last    = xfer && (idx_q == (tok_len(op_q) - 3'd1));
  assign idx_nxt = idx_q + 3'd1;

  token_rom #(.IDENT_DEF(IDENT_DEF)) u_rom (
    .op_i    (op_q),
    .idx_i   (idx_nxt),
    .ident_i (id_q),
    .char_o  (rom_char)
  );

`ifdef CASE_MIX_EN
  logic tog_q, tog_d;
  // Toggle advances on every transferred letter; the next letter sees it.
  assign tog_d    = tog_q ^ (xfer && (out_char_q != CH_SPACE));
  assign nxt_char = (tog_d && (rom_char != CH_SPACE)) ? (rom_char & 8'hDF) : rom_char;

  // Case-mix toggle register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) tog_q <= 1'b0;
    else       tog_q <= tog_d;
  end
`else
  assign nxt_char = rom_char;
`endif

  // Depth changes only once a token's last char has gone; FLUSH runs as CLOSE.
  always_comb begin
    depth_d = depth_q;
    if (last && (op_q == OP_OPEN))       depth_d = depth_q + DEPTH_ONE;
    else if (last && (op_q == OP_CLOSE)) depth_d = depth_q - DEPTH_ONE;
    err_d = err_q | reject;
  end

  // Depth, sticky error and balance flag registered together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      depth_q    <= '0;
      err_q      <= 1'b0;
      balanced_q <= 1'b1;
    end else begin
      depth_q    <= depth_d;
      err_q      <= err_d;
      balanced_q <= (depth_d == '0) && !err_d;
    end
  end

  // Command acceptance and character sequencing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_OPEN;
      id_q        <= 8'h00;
      idx_q       <= 3'd0;
      out_valid_q <= 1'b0;
      out_char_q  <= CH_SPACE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (acc && !reject) begin
            if (bus.cmd_op == OP_FLUSH) begin
              if (depth_q != '0) begin
                state_q     <= ST_FLUSH;
                op_q        <= OP_CLOSE;
                idx_q       <= 3'd0;
                out_valid_q <= 1'b1;
                out_char_q  <= CH_SPACE;
              end
            end else begin
              state_q     <= ST_EMIT;
              op_q        <= bus.cmd_op;
              id_q        <= bus.cmd_char;
              idx_q       <= 3'd0;
              out_valid_q <= 1'b1;
              out_char_q  <= CH_SPACE;
            end
          end
        end
        ST_EMIT, ST_FLUSH: begin
          if (last) begin
            idx_q      <= 3'd0;
            out_char_q <= CH_SPACE;
            // Another " end" follows only while depth stays above zero.
            if (!((state_q == ST_FLUSH) && (depth_q > DEPTH_ONE))) begin
              out_valid_q <= 1'b0;
              state_q     <= ST_IDLE;
            end
          end else if (xfer) begin
            idx_q      <= idx_nxt;
            out_char_q <= nxt_char;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_block_stream_emitter.sv
// Directed table-driven bench for block_stream_emitter.
module tb_block_stream_emitter;
  import block_stream_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] depth;
  logic       balanced, err;

  always #5 clk = ~clk;

  block_stream_emitter_if bus();

  block_stream_emitter #(.DEPTH_W(8), .IDENT_DEF(8'h78)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .depth    (depth),
    .balanced (balanced),
    .err      (err)
  );

  typedef struct {
    op_e        op;
    logic [7:0] ch;
    string      exp;
    int         dep;
    logic       e;
    logic       bal;
  } vec_t;

  vec_t  vecs[11];
  int    checks = 0;
  int    errors = 0;
  logic  tb_tog = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
    end
  endtask

  // Applies the expected upper/lower alternation when case mixing is built in.
  task automatic mix_exp(inout string s);
`ifdef CASE_MIX_EN
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] != 8'h20) begin
        if (tb_tog) s.putc(i, 8'(s[i] & 8'hDF));
        tb_tog = ~tb_tog;
      end
    end
`else
    s = s;
`endif
  endtask

  // Issue one command with out_ready=1 and gather the resulting characters.
  task automatic run_cmd(input op_e op, input logic [7:0] ch, output string got,
                         output logic busy_ok);
    int cyc;
    got     = "";
    busy_ok = 1'b1;
    chk("ready_before_cmd", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_char  = ch;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    for (cyc = 0; cyc < 64; cyc++) begin
      if (!bus.out_valid) break;
      got = $sformatf("%s%c", got, bus.out_char);
      if (bus.cmd_ready) busy_ok = 1'b0;
      @(posedge clk); #1;
    end
    chk("emit_timeout", (cyc < 64), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    string got, exp;
    logic  busy_ok, held_ok, stalled;
    logic [7:0] prev;
    int    cyc;

    vecs[0]  = '{OP_OPEN,  8'h00, " begin",       1, 1'b0, 1'b0};
    vecs[1]  = '{OP_CLOSE, 8'h00, " end",         0, 1'b0, 1'b1};
    vecs[2]  = '{OP_IDENT, 8'h41, " x",           0, 1'b0, 1'b1};
    vecs[3]  = '{OP_IDENT, 8'h71, " q",           0, 1'b0, 1'b1};
    vecs[4]  = '{OP_OPEN,  8'h00, " begin",       1, 1'b0, 1'b0};
    vecs[5]  = '{OP_OPEN,  8'h00, " begin",       2, 1'b0, 1'b0};
    vecs[6]  = '{OP_OPEN,  8'h00, " begin",       3, 1'b0, 1'b0};
    vecs[7]  = '{OP_FLUSH, 8'h00, " end end end", 0, 1'b0, 1'b1};
    vecs[8]  = '{OP_FLUSH, 8'h00, "",             0, 1'b0, 1'b1};
    vecs[9]  = '{OP_CLOSE, 8'h00, "",             0, 1'b1, 1'b0};
    vecs[10] = '{OP_OPEN,  8'h00, " begin",       1, 1'b1, 1'b0};

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_OPEN;
    bus.cmd_char  = 8'h00;
    bus.out_ready = 1'b1;
    reset         = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_char",  bus.out_char, 8'h20);
    chk("rst_depth",     depth, 0);
    chk("rst_balanced",  balanced, 1);
    chk("rst_err",       err, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      exp = vecs[i].exp;
      mix_exp(exp);
      run_cmd(vecs[i].op, vecs[i].ch, got, busy_ok);
      chk_str($sformatf("vec%0d_stream", i), got, exp);
      chk($sformatf("vec%0d_depth", i),    depth, vecs[i].dep);
      chk($sformatf("vec%0d_err", i),      err, vecs[i].e);
      chk($sformatf("vec%0d_balanced", i), balanced, vecs[i].bal);
      chk($sformatf("vec%0d_busy", i),     busy_ok, 1);
      chk($sformatf("vec%0d_ready", i),    bus.cmd_ready, 1);
    end

    // Back-pressure: out_ready alternates, held char must not change.
    exp = " begin";
    mix_exp(exp);
    got           = "";
    held_ok       = 1'b1;
    stalled       = 1'b0;
    prev          = 8'h00;
    bus.out_ready = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_OPEN;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    for (cyc = 0; cyc < 64; cyc++) begin
      if (!bus.out_valid) break;
      if (stalled && (bus.out_char != prev)) held_ok = 1'b0;
      bus.out_ready = cyc[0];
      if (bus.out_ready) got = $sformatf("%s%c", got, bus.out_char);
      stalled = !bus.out_ready;
      prev    = bus.out_char;
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    chk("stall_timeout", (cyc < 64), 1);
    chk_str("stall_stream", got, exp);
    chk("stall_hold", held_ok, 1);
    chk("stall_depth", depth, 2);

    // Reset in the middle of " begin": token aborted, no depth change kept.
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_OPEN;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_valid_pre", bus.out_valid, 1);
    reset = 1'b1;
    #1;
    tb_tog = 1'b0;
    chk("mid_rst_valid",    bus.out_valid, 0);
    chk("mid_rst_depth",    depth, 0);
    chk("mid_rst_err",      err, 0);
    chk("mid_rst_balanced", balanced, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", bus.cmd_ready, 1);
    exp = " begin";
    mix_exp(exp);
    run_cmd(OP_OPEN, 8'h00, got, busy_ok);
    chk_str("post_rst_stream", got, exp);
    chk("post_rst_depth", depth, 1);
    chk("post_rst_balanced", balanced, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
